regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl_pkg.sv | 10 +
 rtl/regfile_wb_ctrl_if.sv | 43 ++++
 rtl/regfile_wb_arb.sv | 38 +++
 rtl/regfile_wb_ctrl.sv | 88 ++++++++
 tb/tb_regfile_wb_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared types for the register-file writeback controller
package regfile_wb_ctrl_pkg;
   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;
   typedef enum logic {REQ_EX = 1'b0, REQ_MEM = 1'b1} req_e;

   function automatic logic is_x0(input reg_idx_t r);
      return r == '0;
   endfunction
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - issue, writeback, register-file and scoreboard-query signal bundle
interface regfile_wb_ctrl_if;
   import regfile_wb_ctrl_pkg::*;

   logic     issue_en_i;
   reg_idx_t issue_rd_i;
   logic     ex_valid_i;
   reg_idx_t ex_rd_i;
   word_t    ex_data_i;
   logic     ex_ready_o;
   logic     mem_valid_i;
   reg_idx_t mem_rd_i;
   word_t    mem_data_i;
   logic     mem_ready_o;
   logic     rf_wr_en_o;
   reg_idx_t rf_wr_addr_o;
   word_t    rf_wr_data_o;
   reg_idx_t chk_addr1_i;
   reg_idx_t chk_addr2_i;
   logic     busy1_o;
   logic     busy2_o;
   logic     byp_hit1_o;
   logic     byp_hit2_o;
   word_t    byp_data_o;

   modport master (
      output issue_en_i, issue_rd_i,
      output ex_valid_i, ex_rd_i, ex_data_i, input ex_ready_o,
      output mem_valid_i, mem_rd_i, mem_data_i, input mem_ready_o,
      input  rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      output chk_addr1_i, chk_addr2_i, input busy1_o, busy2_o,
      input  byp_hit1_o, byp_hit2_o, byp_data_o
   );

   modport slave (
      input  issue_en_i, issue_rd_i,
      input  ex_valid_i, ex_rd_i, ex_data_i, output ex_ready_o,
      input  mem_valid_i, mem_rd_i, mem_data_i, output mem_ready_o,
      output rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      input  chk_addr1_i, chk_addr2_i, output busy1_o, busy2_o,
      output byp_hit1_o, byp_hit2_o, byp_data_o
   );
endinterface

// File: rtl/regfile_wb_arb.sv
// rtl/regfile_wb_arb.sv - 2-way writeback arbiter (execute vs load) with round-robin pointer
module regfile_wb_arb
   import regfile_wb_ctrl_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_valid,
   input  logic mem_valid,
   output logic ex_grant,
   output logic mem_grant
);
   req_e prio;
   req_e winner;
   logic contested;

   assign contested = ex_valid && mem_valid;

   // The pointer only matters when both requesters compete; fixed mode always favours ex.
   always_comb begin
      winner = REQ_EX;
      if (mem_valid && !ex_valid)
         winner = REQ_MEM;
      else if (contested && RR_EN && prio == REQ_MEM)
         winner = REQ_MEM;
   end

   assign ex_grant  = !rst && ex_valid  && winner == REQ_EX;
   assign mem_grant = !rst && mem_valid && winner == REQ_MEM;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prio <= REQ_EX;
      else if (RR_EN && contested)
         prio <= (winner == REQ_EX) ? REQ_MEM : REQ_EX;
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - writeback arbitration, busy scoreboard and write-port register (bypass via REGFILE_WB_BYPASS_EN)
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input logic               clk_i,
   input logic               reset_i,
   regfile_wb_ctrl_if.slave  bus
);
   logic        ex_grant;
   logic        mem_grant;
   logic        fire;
   logic        wr_real;
   reg_idx_t    wr_rd;
   word_t       wr_data;
   logic [31:1] sb;
   logic [31:1] sb_next;
   logic [31:0] sb_full;
   logic        wr_en_q;
   reg_idx_t    wr_addr_q;
   word_t       wr_data_q;
   logic        hit1;
   logic        hit2;

   regfile_wb_arb #(.RR_EN(RR_EN != 0)) u_arb (
      .clk       (clk_i),
      .rst       (reset_i),
      .ex_valid  (bus.ex_valid_i),
      .mem_valid (bus.mem_valid_i),
      .ex_grant  (ex_grant),
      .mem_grant (mem_grant)
   );

   assign bus.ex_ready_o  = ex_grant;
   assign bus.mem_ready_o = mem_grant;

   assign fire    = ex_grant || mem_grant;
   assign wr_rd   = ex_grant ? bus.ex_rd_i   : bus.mem_rd_i;
   assign wr_data = ex_grant ? bus.ex_data_i : bus.mem_data_i;
   assign wr_real = fire && !is_x0(wr_rd);

   // Set is applied after clear so a same-edge issue of a retiring register keeps it busy.
   always_comb begin
      sb_next = sb;
      if (wr_real)
         sb_next[wr_rd] = 1'b0;
      if (bus.issue_en_i && !is_x0(bus.issue_rd_i))
         sb_next[bus.issue_rd_i] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sb        <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         sb      <= sb_next;
         wr_en_q <= wr_real;
         if (wr_real) begin
            wr_addr_q <= wr_rd;
            wr_data_q <= wr_data;
         end
      end
   end

   assign bus.rf_wr_en_o   = wr_en_q;
   assign bus.rf_wr_addr_o = wr_addr_q;
   assign bus.rf_wr_data_o = wr_data_q;

`ifdef REGFILE_WB_BYPASS_EN
   assign hit1 = wr_en_q && wr_addr_q == bus.chk_addr1_i && !is_x0(bus.chk_addr1_i);
   assign hit2 = wr_en_q && wr_addr_q == bus.chk_addr2_i && !is_x0(bus.chk_addr2_i);
   assign bus.byp_data_o = wr_data_q;
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
   assign bus.byp_data_o = '0;
`endif

   // x0 never reads busy: bit 0 of the widened view is hard-wired low.
   assign sb_full        = {sb, 1'b0};
   assign bus.busy1_o    = sb_full[bus.chk_addr1_i] && !hit1;
   assign bus.busy2_o    = sb_full[bus.chk_addr2_i] && !hit2;
   assign bus.byp_hit1_o = hit1;
   assign bus.byp_hit2_o = hit2;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - randomized and directed bench for regfile_wb_ctrl (REGFILE_WB_BYPASS_EN aware)
module tb_regfile_wb_ctrl;
   import regfile_wb_ctrl_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_ctrl_if bus ();
   regfile_wb_ctrl_if bus_fp ();

   regfile_wb_ctrl #(.RR_EN(1)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
   regfile_wb_ctrl #(.RR_EN(0)) dut_fp (.clk_i(clk), .reset_i(rst), .bus(bus_fp));

   int n_tests = 0;
   int n_fail  = 0;

   // Driven stimulus of the round-robin instance, mirrored for the model.
   logic        t_ev, t_mv, t_ien;
   logic [4:0]  t_er, t_mr, t_ird, t_c1, t_c2;
   logic [31:0] t_ed, t_md;

   // Reference model: busy set, whose turn the next contest is, and last register-file write.
   bit          m_busy [32];
   bit          m_ex_turn;
   bit          m_wen;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_ex_turn = 1'b1;
      m_wen = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic apply(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic ien, input logic [4:0] ird,
                        input logic [4:0] c1, input logic [4:0] c2);
      t_ev = ev; t_er = er; t_ed = ed; t_mv = mv; t_mr = mr; t_md = md;
      t_ien = ien; t_ird = ird; t_c1 = c1; t_c2 = c2;
      bus.ex_valid_i = ev;  bus.ex_rd_i = er;  bus.ex_data_i = ed;
      bus.mem_valid_i = mv; bus.mem_rd_i = mr; bus.mem_data_i = md;
      bus.issue_en_i = ien; bus.issue_rd_i = ird;
      bus.chk_addr1_i = c1; bus.chk_addr2_i = c2;
   endtask

   task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
      apply(0, 0, 0, 0, 0, 0, 0, 0, c1, c2);
   endtask

   function automatic bit exp_ex_ready();
      return t_ev && (!t_mv || m_ex_turn);
   endfunction

   function automatic bit exp_mem_ready();
      return t_mv && !exp_ex_ready();
   endfunction

   function automatic bit exp_hit(input logic [4:0] c);
      return BYP && m_wen && m_addr == c && c != 0;
   endfunction

   function automatic bit exp_busy(input logic [4:0] c);
      return c != 0 && m_busy[c] && !exp_hit(c);
   endfunction

   // Advance one clock and apply the behavioural rules to the model.
   task automatic tick();
      bit ex_won, granted;
      logic [4:0] rd;
      logic [31:0] d;
      ex_won  = exp_ex_ready();
      granted = t_ev || t_mv;
      rd = ex_won ? t_er : t_mr;
      d  = ex_won ? t_ed : t_md;
      @(posedge clk);
      m_wen = granted && rd != 0;
      if (m_wen) begin
         m_addr = rd;
         m_data = d;
         m_busy[rd] = 1'b0;
      end
      if (t_ien && t_ird != 0) m_busy[t_ird] = 1'b1;
      if (t_ev && t_mv) m_ex_turn = !ex_won;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(0, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      apply(1, 4, 32'h11, 1, 6, 32'h22, 1, 4, 4, 6);
      @(posedge clk);
      #1;
      n_tests++; if (bus.ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_ready got %0b want 0", bus.ex_ready_o); end
      n_tests++; if (bus.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got %0b want 0", bus.mem_ready_o); end
      n_tests++; if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0b want 0", bus.rf_wr_en_o); end
      n_tests++; if (bus.rf_wr_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0h want 0", bus.rf_wr_addr_o); end
      n_tests++; if (bus.rf_wr_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data got %0h want 0", bus.rf_wr_data_o); end
      n_tests++; if (bus.busy1_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %0b want 0", bus.busy1_o); end
      n_tests++; if (bus.byp_hit2_o !== 1'b0 || bus.byp_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_byp got %0b/%0h want 0/0", bus.byp_hit2_o, bus.byp_data_o); end
      idle(0, 0);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_tests++; if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ex_ready got %0b want 1", bus.ex_ready_o); end
      tick();
      n_tests++; if (bus.rf_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL single_wr_en got %0b want 1", bus.rf_wr_en_o); end
      n_tests++; if (bus.rf_wr_addr_o !== 5'd5) begin n_fail++; $display("FAIL single_wr_addr got %0h want 5", bus.rf_wr_addr_o); end
      n_tests++; if (bus.rf_wr_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wr_data got %0h want deadbeef", bus.rf_wr_data_o); end
      idle(0, 0);
      tick();
      n_tests++; if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_pulse got %0b want 0", bus.rf_wr_en_o); end
      n_tests++; if (bus.rf_wr_addr_o !== 5'd5 || bus.rf_wr_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold got %0h/%0h want 5/deadbeef", bus.rf_wr_addr_o, bus.rf_wr_data_o); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1, 5'(1 + i), 32'h100 + i, 1, 5'(11 + i), 32'h200 + i, 0, 0, 0, 0);
         #1;
         n_tests++; if (bus.ex_ready_o !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_ex_ready[%0d] got %0b want %0b", i, bus.ex_ready_o, i % 2 == 0); end
         n_tests++; if (bus.mem_ready_o !== (i % 2 == 1)) begin n_fail++; $display("FAIL rr_mem_ready[%0d] got %0b want %0b", i, bus.mem_ready_o, i % 2 == 1); end
         tick();
         n_tests++; if (bus.rf_wr_addr_o !== ((i % 2 == 0) ? 5'(1 + i) : 5'(11 + i))) begin n_fail++; $display("FAIL rr_wr_addr[%0d] got %0h", i, bus.rf_wr_addr_o); end
      end
      idle(0, 0);
      tick();
   endtask

   task automatic test_fixed_priority();
      for (int i = 0; i < 4; i++) begin
         bus_fp.ex_valid_i = 1'b1;  bus_fp.ex_rd_i = 5'(20 + i);  bus_fp.ex_data_i = 32'h300 + i;
         bus_fp.mem_valid_i = 1'b1; bus_fp.mem_rd_i = 5'(25 + i); bus_fp.mem_data_i = 32'h400 + i;
         #1;
         n_tests++; if (bus_fp.ex_ready_o !== 1'b1 || bus_fp.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL fixed_ready[%0d] got ex=%0b mem=%0b want ex=1 mem=0", i, bus_fp.ex_ready_o, bus_fp.mem_ready_o); end
         @(posedge clk);
         #1;
         n_tests++; if (bus_fp.rf_wr_addr_o !== 5'(20 + i) || bus_fp.rf_wr_data_o !== 32'h300 + i) begin n_fail++; $display("FAIL fixed_wr[%0d] got %0h/%0h", i, bus_fp.rf_wr_addr_o, bus_fp.rf_wr_data_o); end
      end
      bus_fp.ex_valid_i = 1'b0;
      bus_fp.mem_valid_i = 1'b0;
   endtask

   task automatic test_scoreboard();
      apply(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      tick();
      idle(7, 0);
      #1;
      n_tests++; if (bus.busy1_o !== 1'b1) begin n_fail++; $display("FAIL sb_busy_after_issue got %0b want 1", bus.busy1_o); end
      apply(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
      #1;
      n_tests++; if (bus.mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_mem_ready got %0b want 1", bus.mem_ready_o); end
      tick();
      idle(7, 0);
      #1;
      n_tests++; if (bus.busy1_o !== 1'b0) begin n_fail++; $display("FAIL sb_busy_after_grant got %0b want 0", bus.busy1_o); end
      apply(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      tick();
      apply(1, 7, 32'h78, 0, 0, 0, 1, 7, 7, 0);
      tick();
      idle(7, 0);
      tick();
      n_tests++; if (bus.busy1_o !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %0b want 1", bus.busy1_o); end
      apply(0, 0, 0, 1, 7, 32'h79, 0, 0, 0, 0);
      tick();
      idle(0, 0);
      tick();
   endtask

   task automatic test_rd_zero();
      apply(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      tick();
      apply(1, 0, 32'h1234, 0, 0, 0, 0, 0, 9, 0);
      #1;
      n_tests++; if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ex_ready got %0b want 1", bus.ex_ready_o); end
      tick();
      n_tests++; if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en got %0b want 0", bus.rf_wr_en_o); end
      n_tests++; if (bus.rf_wr_addr_o !== m_addr || bus.rf_wr_data_o !== m_data) begin n_fail++; $display("FAIL x0_hold got %0h/%0h want %0h/%0h", bus.rf_wr_addr_o, bus.rf_wr_data_o, m_addr, m_data); end
      n_tests++; if (bus.busy1_o !== 1'b1) begin n_fail++; $display("FAIL x0_sb_unchanged got %0b want 1", bus.busy1_o); end
      apply(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
      tick();
      idle(0, 0);
      tick();
   endtask

   task automatic test_bypass();
      apply(1, 3, 32'hA5, 0, 0, 0, 1, 3, 0, 0);
      tick();
      idle(0, 3);
      #1;
      n_tests++; if (bus.byp_hit2_o !== BYP) begin n_fail++; $display("FAIL byp_hit2 got %0b want %0b", bus.byp_hit2_o, BYP); end
      n_tests++; if (bus.byp_data_o !== (BYP ? 32'hA5 : 32'h0)) begin n_fail++; $display("FAIL byp_data got %0h want %0h", bus.byp_data_o, BYP ? 32'hA5 : 32'h0); end
      n_tests++; if (bus.busy2_o !== !BYP) begin n_fail++; $display("FAIL byp_busy2 got %0b want %0b", bus.busy2_o, !BYP); end
      apply(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0);
      tick();
      idle(0, 0);
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         apply($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         #1;
         n_tests++; if (bus.ex_ready_o !== exp_ex_ready() || bus.mem_ready_o !== exp_mem_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got %0b%0b want %0b%0b", n, bus.ex_ready_o, bus.mem_ready_o, exp_ex_ready(), exp_mem_ready()); end
         n_tests++; if (bus.busy1_o !== exp_busy(t_c1) || bus.busy2_o !== exp_busy(t_c2)) begin n_fail++; $display("FAIL rnd_busy[%0d] got %0b%0b want %0b%0b", n, bus.busy1_o, bus.busy2_o, exp_busy(t_c1), exp_busy(t_c2)); end
         n_tests++; if (bus.byp_hit1_o !== exp_hit(t_c1) || bus.byp_hit2_o !== exp_hit(t_c2)) begin n_fail++; $display("FAIL rnd_byp_hit[%0d] got %0b%0b want %0b%0b", n, bus.byp_hit1_o, bus.byp_hit2_o, exp_hit(t_c1), exp_hit(t_c2)); end
         n_tests++; if (bus.byp_data_o !== (BYP ? m_data : 32'h0)) begin n_fail++; $display("FAIL rnd_byp_data[%0d] got %0h want %0h", n, bus.byp_data_o, BYP ? m_data : 32'h0); end
         tick();
         n_tests++; if (bus.rf_wr_en_o !== m_wen || bus.rf_wr_addr_o !== m_addr || bus.rf_wr_data_o !== m_data) begin n_fail++; $display("FAIL rnd_wr[%0d] got %0b/%0h/%0h want %0b/%0h/%0h", n, bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o, m_wen, m_addr, m_data); end
      end
   endtask

   task automatic test_reset_mid();
      apply(1, 12, 32'hC0FFEE, 0, 0, 0, 1, 12, 12, 0);
      tick();
      apply(1, 13, 32'h1313, 1, 14, 32'h1414, 0, 0, 12, 0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_tests++; if (bus.ex_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %0b%0b want 00", bus.ex_ready_o, bus.mem_ready_o); end
      n_tests++; if (bus.rf_wr_en_o !== 1'b0 || bus.rf_wr_addr_o !== 5'd0 || bus.rf_wr_data_o !== 32'd0) begin n_fail++; $display("FAIL midrst_wr got %0b/%0h/%0h want 0/0/0", bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o); end
      n_tests++; if (bus.busy1_o !== 1'b0 || bus.byp_hit1_o !== 1'b0 || bus.byp_data_o !== 32'd0) begin n_fail++; $display("FAIL midrst_sb_byp got %0b/%0b/%0h want 0/0/0", bus.busy1_o, bus.byp_hit1_o, bus.byp_data_o); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_tests++; if (bus.ex_ready_o !== 1'b1 || bus.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_first_contest got %0b%0b want 10", bus.ex_ready_o, bus.mem_ready_o); end
      tick();
      n_tests++; if (bus.rf_wr_addr_o !== 5'd13 || bus.rf_wr_data_o !== 32'h1313) begin n_fail++; $display("FAIL midrst_first_write got %0h/%0h want d/1313", bus.rf_wr_addr_o, bus.rf_wr_data_o); end
      idle(0, 0);
      tick();
   endtask

   initial begin
      bus_fp.issue_en_i = 1'b0;  bus_fp.issue_rd_i = '0;
      bus_fp.ex_valid_i = 1'b0;  bus_fp.ex_rd_i = '0;  bus_fp.ex_data_i = '0;
      bus_fp.mem_valid_i = 1'b0; bus_fp.mem_rd_i = '0; bus_fp.mem_data_i = '0;
      bus_fp.chk_addr1_i = '0;   bus_fp.chk_addr2_i = '0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_fixed_priority();
      test_scoreboard();
      test_rd_zero();
      test_bypass();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
